// File: rtl/mult_pkg.sv
// Types and helpers shared by the multiplier datapath and its product accumulator.
// Includes the generate/propagate prefix cells that the adders reuse.
package mult_pkg;

    localparam int unsigned PROD_W_DEFAULT = 8;
    localparam int unsigned ACC_W_DEFAULT  = 12;
    localparam int unsigned TERMS_DEFAULT  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        DONE  = 2'b10
    } acc_state_e;

    // Generate/propagate pair carried through the prefix tree.
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // GREY cell: group generate only, used where the prefix already reaches bit 0.
    function automatic logic grey_cell(input gp_t hi, input logic g_lo);
        return hi.g | (hi.p & g_lo);
    endfunction

    // BLACK cell: merges two adjacent groups into one generate/propagate pair.
    function automatic gp_t black_cell(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/acc_prefix_adder.sv
// Combinational W-bit Sklansky prefix adder (carry-in 0) built from GREY/BLACK cells.
module acc_prefix_adder
    import mult_pkg::*;
#(
    parameter int unsigned W = 12
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int unsigned LVLS = $clog2(W);

    gp_t gp [0:LVLS][0:W-1];

    always_comb begin
        sum  = '0;
        cout = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            gp[0][i].g = a[i] & b[i];
            gp[0][i].p = a[i] ^ b[i];
        end
        // At level l every bit with bit l of its index set merges with the top of the lower half-block.
        for (int unsigned l = 0; l < LVLS; l++) begin
            for (int unsigned i = 0; i < W; i++) begin
                if (((i >> l) & 32'd1) != 32'd0) begin
                    if ((i >> (l + 1)) == 32'd0) begin
                        gp[l+1][i].g = grey_cell(gp[l][i], gp[l][((i >> l) << l) - 1].g);
                        gp[l+1][i].p = 1'b0;
                    end else begin
                        gp[l+1][i] = black_cell(gp[l][i], gp[l][((i >> l) << l) - 1]);
                    end
                end else begin
                    gp[l+1][i] = gp[l][i];
                end
            end
        end
        sum[0] = gp[0][0].p;
        for (int unsigned i = 1; i < W; i++) begin
            sum[i] = gp[0][i].p ^ gp[LVLS][i-1].g;
        end
        cout = gp[LVLS][W-1].g;
    end

endmodule

// File: rtl/prod_accumulator.sv
// Accumulates groups of multiplier products into a wrapped sum with term count and
// sticky carry-out flag, with valid/ready handshakes on both sides.
module prod_accumulator
    import mult_pkg::*;
#(
    parameter int unsigned PROD_W = PROD_W_DEFAULT,
    parameter int unsigned ACC_W  = ACC_W_DEFAULT,
    parameter int unsigned TERMS  = TERMS_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PROD_W-1:0]            in_prod,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             out_acc,
    output logic [$clog2(TERMS+1)-1:0]   out_count,
    output logic                         out_ovf
);

    localparam int unsigned CNT_W = $clog2(TERMS + 1);

    acc_state_e       state_q;
    acc_state_e       state_d;
    logic [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0] count_d;
    logic             ovf_d;
    logic [ACC_W-1:0] add_sum;
    logic             add_cout;
    logic [CNT_W-1:0] count_inc;
    logic             accept;

    acc_prefix_adder #(
        .W (ACC_W)
    ) u_adder (
        .a    (out_acc),
        .b    (ACC_W'(in_prod)),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign accept    = in_valid & in_ready;
    assign count_inc = out_count + CNT_W'(1);

    // Next-state and next-register values; nothing moves without an accept or a result take.
    always_comb begin
        state_d = state_q;
        acc_d   = out_acc;
        count_d = out_count;
        ovf_d   = out_ovf;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = ACC_W'(in_prod);
                    count_d = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = (in_last || (TERMS == 1)) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d   = add_sum;
                    count_d = count_inc;
                    ovf_d   = out_ovf | add_cout;
                    state_d = (in_last || (count_inc == CNT_W'(TERMS))) ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake flags are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            out_acc   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_acc   <= acc_d;
            out_count <= count_d;
            out_ovf   <= ovf_d;
            out_valid <= (state_d == DONE);
            in_ready  <= (state_d != DONE);
        end
    end

endmodule

// File: tb/tb_prod_accumulator.sv
// Scoreboard bench for prod_accumulator: default DUT (a) and an ACC_W=9 DUT (b).
module tb_prod_accumulator;

    logic       clk;
    logic       rst_n;

    logic       in_valid_a, in_ready_a, in_last_a, out_valid_a, out_ready_a, out_ovf_a;
    logic [7:0] in_prod_a;
    logic [11:0] out_acc_a;
    logic [2:0] out_count_a;

    logic       in_valid_b, in_ready_b, in_last_b, out_valid_b, out_ready_b, out_ovf_b;
    logic [7:0] in_prod_b;
    logic [8:0] out_acc_b;
    logic [2:0] out_count_b;

    typedef struct {
        int acc;
        int cnt;
        int ovf;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_checks;
    int   n_fail;

    prod_accumulator u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .in_prod   (in_prod_a),
        .in_last   (in_last_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a),
        .out_acc   (out_acc_a),
        .out_count (out_count_a),
        .out_ovf   (out_ovf_a)
    );

    prod_accumulator #(.ACC_W(9)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .in_prod   (in_prod_b),
        .in_last   (in_last_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .out_acc   (out_acc_b),
        .out_count (out_count_b),
        .out_ovf   (out_ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Monitors: one pop per completed result handshake.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_n && out_valid_a && out_ready_a) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_result", 1, 0);
            end else begin
                e = qa.pop_front();
                chk("a_acc", int'(out_acc_a), e.acc);
                chk("a_count", int'(out_count_a), e.cnt);
                chk("a_ovf", int'(out_ovf_a), e.ovf);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_n && out_valid_b && out_ready_b) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_result", 1, 0);
            end else begin
                e = qb.pop_front();
                chk("b_acc", int'(out_acc_b), e.acc);
                chk("b_count", int'(out_count_b), e.cnt);
                chk("b_ovf", int'(out_ovf_b), e.ovf);
            end
        end
    end

    // Offer one product and hold it until accepted; called and returns at posedge+1.
    task automatic beat(input bit sel_b, input int p, input bit last, input int gap);
        logic r;
        int   n;
        n = 0;
        if (sel_b) begin
            in_valid_b = 1'b1; in_prod_b = 8'(p); in_last_b = last;
        end else begin
            in_valid_a = 1'b1; in_prod_a = 8'(p); in_last_a = last;
        end
        forever begin
            @(negedge clk);
            r = sel_b ? in_ready_b : in_ready_a;
            @(posedge clk);
            #1;
            if (r) break;
            n++;
            if (n > 50) begin
                chk("accept_timeout", 1, 0);
                break;
            end
        end
        in_valid_a = 1'b0; in_last_a = 1'b0;
        in_valid_b = 1'b0; in_last_b = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        in_valid_a = 1'b0; in_prod_a = '0; in_last_a = 1'b0; out_ready_a = 1'b1;
        in_valid_b = 1'b0; in_prod_b = '0; in_last_b = 1'b0; out_ready_b = 1'b1;

        // Reset held for 3 cycles
        repeat (3) step();
        chk("rst_out_valid", int'(out_valid_a), 0);
        chk("rst_in_ready", int'(in_ready_a), 0);
        chk("rst_out_acc", int'(out_acc_a), 0);
        chk("rst_out_count", int'(out_count_a), 0);
        chk("rst_out_ovf", int'(out_ovf_a), 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", int'(in_ready_a), 1);
        chk("post_rst_out_valid", int'(out_valid_a), 0);

        // Four back-to-back 15x15 products
        qa.push_back('{900, 4, 0});
        repeat (4) beat(1'b0, 225, 1'b0, 0);
        chk("t2_out_valid", int'(out_valid_a), 1);
        chk("t2_in_ready_bubble", int'(in_ready_a), 0);
        step();
        chk("t2_out_valid_drop", int'(out_valid_a), 0);
        chk("t2_in_ready_back", int'(in_ready_a), 1);

        // Redundant in_last on the final term
        qa.push_back('{10, 4, 0});
        beat(1'b0, 1, 1'b0, 0);
        beat(1'b0, 2, 1'b0, 0);
        beat(1'b0, 3, 1'b0, 0);
        beat(1'b0, 4, 1'b1, 0);
        step();

        // Gapped input, then backpressure with in_valid held high
        out_ready_a = 1'b0;
        qa.push_back('{18, 4, 0});
        beat(1'b0, 3, 1'b0, 2);
        beat(1'b0, 4, 1'b0, 2);
        beat(1'b0, 5, 1'b0, 2);
        beat(1'b0, 6, 1'b0, 0);
        in_valid_a = 1'b1;
        in_prod_a  = 8'd99;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", int'(out_valid_a), 1);
            chk("t3_hold_acc", int'(out_acc_a), 18);
            chk("t3_hold_count", int'(out_count_a), 4);
            chk("t3_hold_in_ready", int'(in_ready_a), 0);
            step();
        end
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        step();
        chk("t3_released", int'(out_valid_a), 0);
        chk("t3_acc_kept", int'(out_acc_a), 18);
        chk("t3_popped", qa.size(), 0);

        // Early termination and a one-term group
        qa.push_back('{16, 2, 0});
        beat(1'b0, 6, 1'b0, 0);
        beat(1'b0, 10, 1'b1, 0);
        qa.push_back('{7, 1, 0});
        beat(1'b0, 7, 1'b1, 0);
        step();

        // Narrow accumulator: wrap and sticky carry, then a clean group
        qb.push_back('{388, 4, 1});
        repeat (4) beat(1'b1, 225, 1'b0, 0);
        qb.push_back('{4, 4, 0});
        repeat (4) beat(1'b1, 1, 1'b0, 0);
        step();

        // Reset in the middle of a group
        beat(1'b0, 100, 1'b0, 0);
        beat(1'b0, 100, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        chk("t6_acc_cleared", int'(out_acc_a), 0);
        chk("t6_count_cleared", int'(out_count_a), 0);
        chk("t6_no_valid", int'(out_valid_a), 0);
        chk("t6_in_ready_low", int'(in_ready_a), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("t6_in_ready_back", int'(in_ready_a), 1);
        qa.push_back('{18, 4, 0});
        beat(1'b0, 3, 1'b0, 0);
        beat(1'b0, 4, 1'b0, 0);
        beat(1'b0, 5, 1'b0, 0);
        beat(1'b0, 6, 1'b0, 0);

        repeat (5) step();
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
